// File: rtl/cu_mc.sv
// Multi-cycle control unit: latches the instruction word and sequences
// FETCH/DECODE/EXEC/MEM with memory wait states, one-level interrupt and HALT.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_FETCH  | instruction read; waits for mem_rdy_in, then loads IR, PC+1
// S_DECODE | one idle cycle to decode the latched opcode
// S_EXEC   | ALU writeback, branch/jump PC load, or RETI
// S_MEM    | LD/ST data access; holds until mem_rdy_in
// S_IRQ    | load interrupt vector, acknowledge, enter service
// S_HALTED | idle until an unserviced interrupt or reset
module cu_mc #(
    parameter int DATA_W = 16,
    parameter int OPC_W  = 4,
    parameter int RA_W   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   ins_in,
    input  logic [1:0]          nz_in,
    input  logic                mem_rdy_in,
    input  logic                irq_in,
    output logic                il_out,
    output logic [1:0]          ps_out,
    output logic                rw_out,
    output logic [3*RA_W-1:0]   rs_out,
    output logic [3:0]          mx_out,
    output logic [3:0]          fs_out,
    output logic                wen_out,
    output logic                iom_out,
    output logic                irq_ack_out
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_IRQ,
        S_HALTED
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_SHR  = 4'h8;
    localparam logic [3:0] OP_LD   = 4'h9;
    localparam logic [3:0] OP_ST   = 4'hA;
    localparam logic [3:0] OP_BRZ  = 4'hB;
    localparam logic [3:0] OP_BRN  = 4'hC;
    localparam logic [3:0] OP_JMP  = 4'hD;
    localparam logic [3:0] OP_RETI = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t             state, state_nxt;
    logic [DATA_W-1:0]  ir;
    logic               ir_ld;
    logic               in_service, in_service_nxt;
    logic [OPC_W-1:0]   opc;
    logic               alu_op;

    assign opc    = ir[DATA_W-1 -: OPC_W];
    assign alu_op = (opc != OP_NOP) && (opc <= OP_SHR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_FETCH;
            ir         <= '0;
            in_service <= 1'b0;
        end else begin
            state      <= state_nxt;
            in_service <= in_service_nxt;
            if (ir_ld)
                ir <= ins_in;
        end
    end

    always_comb begin
        state_nxt      = state;
        in_service_nxt = in_service;
        ir_ld          = 1'b0;
        il_out         = 1'b0;
        ps_out         = 2'b00;
        rw_out         = 1'b0;
        rs_out         = ir[DATA_W-OPC_W-1 -: 3*RA_W];
        mx_out         = 4'b0000;
        fs_out         = 4'b0000;
        wen_out        = 1'b0;
        iom_out        = 1'b0;
        irq_ack_out    = 1'b0;

        case (state)
            S_FETCH: begin
                if (mem_rdy_in) begin
                    il_out    = 1'b1;
                    ps_out    = 2'b01;
                    ir_ld     = 1'b1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opc)
                    OP_NOP:       state_nxt = (irq_in && !in_service) ? S_IRQ : S_FETCH;
                    OP_LD, OP_ST: state_nxt = S_MEM;
                    OP_HALT:      state_nxt = S_HALTED;
                    default:      state_nxt = S_EXEC;
                endcase
            end
            S_EXEC: begin
                if (alu_op) begin
                    fs_out  = opc;
                    wen_out = 1'b1;
                end else if ((opc == OP_JMP) ||
                             (opc == OP_BRZ && nz_in[0]) ||
                             (opc == OP_BRN && nz_in[1])) begin
                    ps_out      = 2'b10;
                    mx_out[3:2] = 2'b01;
                end else if (opc == OP_RETI) begin
                    ps_out         = 2'b10;
                    mx_out[3:2]    = 2'b10;
                    in_service_nxt = 1'b0;
                end
                // Boundary test sees the RETI-cleared flag so a pending irq is taken at once.
                state_nxt = (irq_in && !in_service_nxt) ? S_IRQ : S_FETCH;
            end
            S_MEM: begin
                iom_out     = 1'b1;
                mx_out[3:2] = 2'b01;
                rw_out      = (opc == OP_ST);
                if (mem_rdy_in) begin
                    if (opc == OP_LD) begin
                        wen_out     = 1'b1;
                        mx_out[1:0] = 2'b01;
                    end
                    state_nxt = (irq_in && !in_service) ? S_IRQ : S_FETCH;
                end
            end
            S_IRQ: begin
                ps_out         = 2'b11;
                irq_ack_out    = 1'b1;
                in_service_nxt = 1'b1;
                state_nxt      = S_FETCH;
            end
            S_HALTED: begin
                if (irq_in && !in_service)
                    state_nxt = S_IRQ;
            end
            default: state_nxt = S_FETCH;
        endcase

        if (!rst_n) begin
            il_out      = 1'b0;
            ps_out      = 2'b00;
            rw_out      = 1'b0;
            rs_out      = '0;
            mx_out      = 4'b0000;
            fs_out      = 4'b0000;
            wen_out     = 1'b0;
            iom_out     = 1'b0;
            irq_ack_out = 1'b0;
        end
    end

endmodule

// File: tb/tb_cu_mc.sv
// Directed bench for cu_mc: a table of per-cycle vectors plus hand-written
// interrupt and halt sequences, all with hand-computed expected outputs.
module tb_cu_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] ins_in;
    logic [1:0]  nz_in;
    logic        mem_rdy_in;
    logic        irq_in;
    logic        il_out;
    logic [1:0]  ps_out;
    logic        rw_out;
    logic [11:0] rs_out;
    logic [3:0]  mx_out;
    logic [3:0]  fs_out;
    logic        wen_out;
    logic        iom_out;
    logic        irq_ack_out;

    int n_cmp = 0;
    int n_bad = 0;

    cu_mc #(.DATA_W(16), .OPC_W(4), .RA_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ins_in      (ins_in),
        .nz_in       (nz_in),
        .mem_rdy_in  (mem_rdy_in),
        .irq_in      (irq_in),
        .il_out      (il_out),
        .ps_out      (ps_out),
        .rw_out      (rw_out),
        .rs_out      (rs_out),
        .mx_out      (mx_out),
        .fs_out      (fs_out),
        .wen_out     (wen_out),
        .iom_out     (iom_out),
        .irq_ack_out (irq_ack_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [15:0] ins;
        logic [1:0]  nz;
        logic        rdy;
        logic        irq;
        logic [26:0] exp;
    } vec_t;

    vec_t vt[$];

    // Packed output image: {il, ps, rw, rs, mx, fs, wen, iom, ack}
    function automatic logic [26:0] pk(input logic il, input logic [1:0] ps, input logic rw,
                                       input logic [11:0] rs, input logic [3:0] mx,
                                       input logic [3:0] fs, input logic wen,
                                       input logic iom, input logic ack);
        return {il, ps, rw, rs, mx, fs, wen, iom, ack};
    endfunction

    task automatic add(input logic rst, input logic [15:0] ins, input logic [1:0] nz,
                       input logic rdy, input logic irq, input logic [26:0] exp);
        vec_t v;
        v.rst = rst; v.ins = ins; v.nz = nz; v.rdy = rdy; v.irq = irq; v.exp = exp;
        vt.push_back(v);
    endtask

    // Drive one cycle's inputs after the falling edge, then sample before the rising edge.
    task automatic cyc(input logic rst, input logic [15:0] ins, input logic [1:0] nz,
                       input logic rdy, input logic irq, input logic [26:0] exp,
                       input string name);
        logic [26:0] act;
        @(negedge clk);
        rst_n = rst; ins_in = ins; nz_in = nz; mem_rdy_in = rdy; irq_in = irq;
        #1;
        act = {il_out, ps_out, rw_out, rs_out, mx_out, fs_out, wen_out, iom_out, irq_ack_out};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (il,ps,rw,rs,mx,fs,wen,iom,ack)", name, act, exp);
        end
    endtask

    logic [26:0] z;
    logic [26:0] fetch_0;

    initial begin
        rst_n = 1'b0; ins_in = '0; nz_in = '0; mem_rdy_in = 1'b0; irq_in = 1'b0;
        z       = pk(0, 2'b00, 0, 12'h000, 4'b0000, 4'h0, 0, 0, 0);
        fetch_0 = pk(1, 2'b01, 0, 12'h000, 4'b0000, 4'h0, 0, 0, 0);

        // reset, then ADD with no wait states
        add(0, 16'h1123, 2'b00, 1, 0, z);
        add(0, 16'h1123, 2'b00, 1, 0, z);
        add(0, 16'h1123, 2'b00, 1, 0, z);
        add(1, 16'h1123, 2'b00, 1, 0, fetch_0);
        add(1, 16'h1123, 2'b00, 1, 0, pk(0, 2'b00, 0, 12'h123, 4'b0000, 4'h0, 0, 0, 0));
        add(1, 16'h1123, 2'b00, 1, 0, pk(0, 2'b00, 0, 12'h123, 4'b0000, 4'h1, 1, 0, 0));
        // LD with fetch wait and 3 memory wait states
        add(1, 16'h9450, 2'b00, 0, 0, pk(0, 2'b00, 0, 12'h123, 4'b0000, 4'h0, 0, 0, 0));
        add(1, 16'h9450, 2'b00, 1, 0, pk(1, 2'b01, 0, 12'h123, 4'b0000, 4'h0, 0, 0, 0));
        add(1, 16'h9450, 2'b00, 1, 0, pk(0, 2'b00, 0, 12'h450, 4'b0000, 4'h0, 0, 0, 0));
        add(1, 16'h9450, 2'b00, 0, 0, pk(0, 2'b00, 0, 12'h450, 4'b0100, 4'h0, 0, 1, 0));
        add(1, 16'h9450, 2'b00, 0, 0, pk(0, 2'b00, 0, 12'h450, 4'b0100, 4'h0, 0, 1, 0));
        add(1, 16'h9450, 2'b00, 0, 0, pk(0, 2'b00, 0, 12'h450, 4'b0100, 4'h0, 0, 1, 0));
        add(1, 16'h9450, 2'b00, 1, 0, pk(0, 2'b00, 0, 12'h450, 4'b0101, 4'h0, 1, 1, 0));
        // BRZ taken
        add(1, 16'hB000, 2'b01, 1, 0, pk(1, 2'b01, 0, 12'h450, 4'b0000, 4'h0, 0, 0, 0));
        add(1, 16'hB000, 2'b01, 1, 0, z);
        add(1, 16'hB000, 2'b01, 1, 0, pk(0, 2'b10, 0, 12'h000, 4'b0100, 4'h0, 0, 0, 0));
        // BRZ not taken
        add(1, 16'hB000, 2'b00, 1, 0, fetch_0);
        add(1, 16'hB000, 2'b00, 1, 0, z);
        add(1, 16'hB000, 2'b00, 1, 0, z);
        // BRN taken
        add(1, 16'hC000, 2'b10, 1, 0, fetch_0);
        add(1, 16'hC000, 2'b10, 1, 0, z);
        add(1, 16'hC000, 2'b10, 1, 0, pk(0, 2'b10, 0, 12'h000, 4'b0100, 4'h0, 0, 0, 0));
        // ST with one wait state
        add(1, 16'hA000, 2'b00, 1, 0, fetch_0);
        add(1, 16'hA000, 2'b00, 1, 0, z);
        add(1, 16'hA000, 2'b00, 0, 0, pk(0, 2'b00, 1, 12'h000, 4'b0100, 4'h0, 0, 1, 0));
        add(1, 16'hA000, 2'b00, 1, 0, pk(0, 2'b00, 1, 12'h000, 4'b0100, 4'h0, 0, 1, 0));
        // JMP, NOP, NOT
        add(1, 16'hD000, 2'b00, 1, 0, fetch_0);
        add(1, 16'hD000, 2'b00, 1, 0, z);
        add(1, 16'hD000, 2'b00, 1, 0, pk(0, 2'b10, 0, 12'h000, 4'b0100, 4'h0, 0, 0, 0));
        add(1, 16'h0000, 2'b00, 1, 0, fetch_0);
        add(1, 16'h0000, 2'b00, 1, 0, z);
        add(1, 16'h6120, 2'b00, 1, 0, fetch_0);
        add(1, 16'h6120, 2'b00, 1, 0, pk(0, 2'b00, 0, 12'h120, 4'b0000, 4'h0, 0, 0, 0));
        add(1, 16'h6120, 2'b00, 1, 0, pk(0, 2'b00, 0, 12'h120, 4'b0000, 4'h6, 1, 0, 0));
        // reset clears IR
        add(0, 16'h1123, 2'b00, 1, 0, z);
        add(1, 16'h1123, 2'b00, 0, 0, z);

        foreach (vt[i])
            cyc(vt[i].rst, vt[i].ins, vt[i].nz, vt[i].rdy, vt[i].irq, vt[i].exp,
                $sformatf("vec%0d", i));

        // interrupt during fetch, ignored while in service, retaken after RETI
        cyc(0, 16'h1123, 2'b00, 1, 0, z, "irq_rst0");
        cyc(0, 16'h1123, 2'b00, 1, 0, z, "irq_rst1");
        cyc(1, 16'h1123, 2'b00, 0, 1, z, "irq_fetch_wait");
        cyc(1, 16'h1123, 2'b00, 1, 1, fetch_0, "irq_fetch");
        cyc(1, 16'h1123, 2'b00, 1, 1, pk(0, 2'b00, 0, 12'h123, 4'b0000, 4'h0, 0, 0, 0), "irq_decode");
        cyc(1, 16'h1123, 2'b00, 1, 1, pk(0, 2'b00, 0, 12'h123, 4'b0000, 4'h1, 1, 0, 0), "irq_exec");
        cyc(1, 16'h1123, 2'b00, 1, 0, pk(0, 2'b11, 0, 12'h123, 4'b0000, 4'h0, 0, 0, 1), "irq_enter");
        cyc(1, 16'h1123, 2'b00, 1, 1, pk(1, 2'b01, 0, 12'h123, 4'b0000, 4'h0, 0, 0, 0), "irq_ack_once");
        cyc(1, 16'h1123, 2'b00, 1, 1, pk(0, 2'b00, 0, 12'h123, 4'b0000, 4'h0, 0, 0, 0), "svc_decode");
        cyc(1, 16'h1123, 2'b00, 1, 1, pk(0, 2'b00, 0, 12'h123, 4'b0000, 4'h1, 1, 0, 0), "svc_exec");
        cyc(1, 16'hE000, 2'b00, 1, 1, pk(1, 2'b01, 0, 12'h123, 4'b0000, 4'h0, 0, 0, 0), "svc_irq_ignored");
        cyc(1, 16'hE000, 2'b00, 1, 1, z, "reti_decode");
        cyc(1, 16'hE000, 2'b00, 1, 1, pk(0, 2'b10, 0, 12'h000, 4'b1000, 4'h0, 0, 0, 0), "reti_exec");
        cyc(1, 16'hF000, 2'b00, 1, 0, pk(0, 2'b11, 0, 12'h000, 4'b0000, 4'h0, 0, 0, 1), "reti_irq_direct");
        cyc(1, 16'hF000, 2'b00, 1, 0, fetch_0, "halt_svc_fetch");
        cyc(1, 16'hF000, 2'b00, 1, 1, z, "halt_svc_decode");
        for (int k = 0; k < 3; k++)
            cyc(1, 16'hF000, 2'b00, 1, 1, z, $sformatf("halt_svc_ignore%0d", k));

        // HALT from a clean reset: idle 20 cycles, then an irq wakes it
        cyc(0, 16'hF000, 2'b00, 1, 0, z, "halt_rst");
        cyc(1, 16'hF000, 2'b00, 1, 0, fetch_0, "halt_fetch");
        cyc(1, 16'hF000, 2'b00, 1, 0, z, "halt_decode");
        for (int k = 0; k < 20; k++)
            cyc(1, 16'hF000, 2'(k), k[0], 0, z, $sformatf("halt_idle%0d", k));
        cyc(1, 16'hF000, 2'b00, 1, 1, z, "halt_irq_seen");
        cyc(1, 16'hF000, 2'b00, 1, 1, pk(0, 2'b11, 0, 12'h000, 4'b0000, 4'h0, 0, 0, 1), "halt_irq_enter");
        cyc(1, 16'hF000, 2'b00, 1, 1, fetch_0, "halt_irq_fetch");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
